host_mem_sequencer: RTL

- Host-side scheduler that shares the processor's single-port instruction, parameter and activation memories between a host command/data stream and the internal controller.
- Executes one host command at a time:
  - bulk-load any memory from a valid/ready data stream;
  - run an inference by raising en and waiting for done;
  - stream a region of activation memory back to the host.
- Sits directly above processor_top and drives its sel_ext, *_ext write ports and en.

---
 rtl/host_mem_sequencer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/host_mem_sequencer.sv
// Host-side command sequencer: owns the processor memories while loading or reading back,
// and hands them to the controller for the duration of a RUN.
module host_mem_sequencer #(
  parameter int          WIDTH_ACT_MEM    = 8,
  parameter int          WIDTH_PARAM_MEM  = 128,
  parameter int          WIDTH_INST_MEM   = 80,
  parameter int          WIDTH_ADDR_ACT   = 12,
  parameter int          WIDTH_ADDR_PARAM = 13,
  parameter int          WIDTH_ADDR_INST  = 6,
  parameter int unsigned TIMEOUT_CYCLES   = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [WIDTH_ADDR_PARAM-1:0] cmd_base,
  input  logic [WIDTH_ADDR_PARAM-1:0] cmd_len,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic [WIDTH_PARAM_MEM-1:0]  data_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH_ACT_MEM-1:0]    out_data,
  output logic                        cmd_done,
  output logic                        err,
  output logic                        busy,
  output logic                        sel_ext,
  output logic                        en,
  output logic                        wea_instmem_ext,
  output logic                        wea_parammem_ext,
  output logic                        wea_actmem_ext,
  output logic [WIDTH_ADDR_INST-1:0]  addr_instmem_ext,
  output logic [WIDTH_ADDR_PARAM-1:0] addr_parammem_ext,
  output logic [WIDTH_ADDR_ACT-1:0]   addr_actmem_ext,
  output logic [WIDTH_INST_MEM-1:0]   instmem_in_ext,
  output logic [WIDTH_PARAM_MEM-1:0]  parammem_in_ext,
  output logic [WIDTH_ACT_MEM-1:0]    actmem_in_ext,
  input  logic [WIDTH_ACT_MEM-1:0]    actmem_out,
  input  logic                        done,
  output logic [2:0]                  dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RD_OUT  = 3'd5;

  localparam logic [2:0] OP_LOAD_INST  = 3'd0;
  localparam logic [2:0] OP_LOAD_PARAM = 3'd1;
  localparam logic [2:0] OP_RUN        = 3'd3;
  localparam logic [2:0] OP_READ_ACT   = 3'd4;

  logic [2:0]                  r_state;
  logic [2:0]                  r_op;
  logic [WIDTH_ADDR_PARAM-1:0] r_base;
  logic [WIDTH_ADDR_PARAM-1:0] r_len;
  logic [WIDTH_ADDR_PARAM-1:0] r_cnt;
  logic [31:0]                 r_wdog;
  logic                        r_cmd_ready;
  logic                        r_data_ready;
  logic                        r_out_valid;
  logic [WIDTH_ACT_MEM-1:0]    r_out_data;
  logic                        r_cmd_done;
  logic                        r_err;
  logic                        r_busy;
  logic                        r_sel_ext;
  logic                        r_en;
  logic                        r_wea_inst;
  logic                        r_wea_param;
  logic                        r_wea_act;
  logic [WIDTH_ADDR_INST-1:0]  r_addr_inst;
  logic [WIDTH_ADDR_PARAM-1:0] r_addr_param;
  logic [WIDTH_ADDR_ACT-1:0]   r_addr_act;
  logic [WIDTH_INST_MEM-1:0]   r_inst_in;
  logic [WIDTH_PARAM_MEM-1:0]  r_param_in;
  logic [WIDTH_ACT_MEM-1:0]    r_act_in;

  logic                        w_beat;
  logic                        w_last;
  logic [WIDTH_ADDR_PARAM-1:0] w_addr;
  logic [WIDTH_ADDR_ACT-1:0]   w_addr_next_act;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready/valid outputs are registered, so they are stable for the whole cycle.
  assign w_beat          = r_data_ready & data_valid;
  assign w_last          = (r_cnt == (r_len - WIDTH_ADDR_PARAM'(1)));
  assign w_addr          = r_base + r_cnt;
  assign w_addr_next_act = r_base[WIDTH_ADDR_ACT-1:0] + r_cnt[WIDTH_ADDR_ACT-1:0]
                           + WIDTH_ADDR_ACT'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_base       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_wdog       <= '0;
      r_cmd_ready  <= 1'b0;
      r_data_ready <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_cmd_done   <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_sel_ext    <= 1'b1;
      r_en         <= 1'b0;
      r_wea_inst   <= 1'b0;
      r_wea_param  <= 1'b0;
      r_wea_act    <= 1'b0;
      r_addr_inst  <= '0;
      r_addr_param <= '0;
      r_addr_act   <= '0;
      r_inst_in    <= '0;
      r_param_in   <= '0;
      r_act_in     <= '0;
    end else begin
      r_cmd_done  <= 1'b0;
      r_err       <= 1'b0;
      r_wea_inst  <= 1'b0;
      r_wea_param <= 1'b0;
      r_wea_act   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_op   <= cmd_op;
            r_base <= cmd_base;
            r_len  <= cmd_len;
            r_cnt  <= '0;
            if (cmd_op > OP_READ_ACT) begin
              r_err <= 1'b1;
            end else if (cmd_op != OP_RUN && cmd_len == '0) begin
              r_cmd_done <= 1'b1;
            end else begin
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              if (cmd_op == OP_RUN) begin
                r_state <= S_RUN;
              end else if (cmd_op == OP_READ_ACT) begin
                r_state    <= S_RD_ADDR;
                r_addr_act <= cmd_base[WIDTH_ADDR_ACT-1:0];
              end else begin
                r_state      <= S_LOAD;
                r_data_ready <= 1'b1;
              end
            end
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            case (r_op)
              OP_LOAD_INST: begin
                r_wea_inst  <= 1'b1;
                r_addr_inst <= w_addr[WIDTH_ADDR_INST-1:0];
                r_inst_in   <= data_in[WIDTH_INST_MEM-1:0];
              end
              OP_LOAD_PARAM: begin
                r_wea_param  <= 1'b1;
                r_addr_param <= w_addr;
                r_param_in   <= data_in;
              end
              default: begin
                r_wea_act  <= 1'b1;
                r_addr_act <= w_addr[WIDTH_ADDR_ACT-1:0];
                r_act_in   <= data_in[WIDTH_ACT_MEM-1:0];
              end
            endcase
            r_cnt <= r_cnt + WIDTH_ADDR_PARAM'(1);
            if (w_last) begin
              r_data_ready <= 1'b0;
              r_state      <= S_IDLE;
              r_cmd_done   <= 1'b1;
              r_busy       <= 1'b0;
              r_cmd_ready  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // First RUN cycle hands the memories over; done is only honoured once en is up.
          if (!r_en) begin
            r_en      <= 1'b1;
            r_sel_ext <= 1'b0;
            r_wdog    <= '0;
          end else if (done || (TIMEOUT_CYCLES != 0 && (r_wdog + 32'd1) == TIMEOUT_CYCLES)) begin
            r_en        <= 1'b0;
            r_sel_ext   <= 1'b1;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            if (done) r_cmd_done <= 1'b1;
            else      r_err      <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        S_RD_ADDR: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_out_data  <= actmem_out;
          r_out_valid <= 1'b1;
          r_state     <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_cnt       <= r_cnt + WIDTH_ADDR_PARAM'(1);
            if (w_last) begin
              r_state     <= S_IDLE;
              r_cmd_done  <= 1'b1;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
            end else begin
              r_state    <= S_RD_ADDR;
              r_addr_act <= w_addr_next_act;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready         = r_cmd_ready;
  assign data_ready        = r_data_ready;
  assign out_valid         = r_out_valid;
  assign out_data          = r_out_data;
  assign cmd_done          = r_cmd_done;
  assign err               = r_err;
  assign busy              = r_busy;
  assign sel_ext           = r_sel_ext;
  assign en                = r_en;
  assign wea_instmem_ext   = r_wea_inst;
  assign wea_parammem_ext  = r_wea_param;
  assign wea_actmem_ext    = r_wea_act;
  assign addr_instmem_ext  = r_addr_inst;
  assign addr_parammem_ext = r_addr_param;
  assign addr_actmem_ext   = r_addr_act;
  assign instmem_in_ext    = r_inst_in;
  assign parammem_in_ext   = r_param_in;
  assign actmem_in_ext     = r_act_in;
  assign dbg_state         = r_state;

endmodule
